// File: rtl/modport_bridge.sv
// modport_bridge: AHB-Lite slave to APB bridge, all in the HCLK domain.
// Single AHB transfers become APB SETUP/ENABLE pairs on one of four 64 MB
// slots. HREADYout stalls the AHB data phase until the APB access finishes.
// Optional: define MODPORT_ERR_RESP_EN to answer out-of-window transfers
// with a two-cycle AHB ERROR response instead of silently ignoring them.
module modport_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADYin,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADYout,
    input  logic [31:0] PRDATA,
    output logic [3:0]  PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WWAIT  = 3'd1,
        S_SETUP  = 3'd2,
        S_ENABLE = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    // Captured address-phase request; drives the APB address/direction.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  slot;
    } req_t;

    state_t      state, nxt;
    req_t        req_q;
    logic [31:0] pwdata_q;
    logic [31:0] off;
    logic        in_win;
    logic        addr_phase;
    logic        hit;
    logic        unused_ok;

    // Window test is done on the offset so any 256 MB-aligned base works.
    assign off    = HADDR - BASE_ADDR;
    assign in_win = (off[31:28] == 4'h0);

    // Address phases are only looked at while the bridge shows ready to the
    // master from a state that may start a new APB access.
    assign addr_phase = ((state == S_IDLE) || (state == S_ENABLE)) &&
                        HREADYin && HTRANS[1];
    assign hit        = addr_phase && in_win;

    // Transfer size is irrelevant: every APB access is a full word.
    assign unused_ok = ^{HSIZE, HTRANS[0], off[25:0]};

    // Read data passes straight through; the master samples it in ENABLE.
    assign HRDATA = PRDATA;

    assign PADDR  = req_q.addr;
    assign PWRITE = req_q.write;
    assign PWDATA = pwdata_q;

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_IDLE;
        else        state <= nxt;
    end

    // Latch the request when a transfer is accepted.
    always_ff @(posedge HCLK) begin
        if (HRESET)   req_q <= '0;
        else if (hit) req_q <= '{addr: HADDR, write: HWRITE, slot: off[27:26]};
    end

    // Write data is only valid in the AHB data phase, i.e. during WWAIT.
    always_ff @(posedge HCLK) begin
        if (HRESET)                 pwdata_q <= '0;
        else if (state == S_WWAIT)  pwdata_q <= HWDATA;
    end

    // Next-state decode and state-derived bus outputs.
    always_comb begin
        nxt       = state;
        HREADYout = 1'b1;
        HRESP     = RESP_OKAY;
        PSELx     = 4'b0000;
        PENABLE   = 1'b0;
        case (state)
            S_IDLE, S_ENABLE: begin
                if (state == S_ENABLE) begin
                    PSELx   = 4'b0001 << req_q.slot;
                    PENABLE = 1'b1;
                end
                if (hit)
                    nxt = HWRITE ? S_WWAIT : S_SETUP;
`ifdef MODPORT_ERR_RESP_EN
                else if (addr_phase)
                    nxt = S_ERR1;
`endif
                else
                    nxt = S_IDLE;
            end
            S_WWAIT: begin
                HREADYout = 1'b0;
                nxt       = S_SETUP;
            end
            S_SETUP: begin
                HREADYout = 1'b0;
                PSELx     = 4'b0001 << req_q.slot;
                nxt       = S_ENABLE;
            end
`ifdef MODPORT_ERR_RESP_EN
            // Two-cycle AHB error: first cycle stalls, second completes.
            S_ERR1: begin
                HREADYout = 1'b0;
                HRESP     = RESP_ERROR;
                nxt       = S_ERR2;
            end
            S_ERR2: begin
                HRESP = RESP_ERROR;
                nxt   = S_IDLE;
            end
`endif
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_modport_bridge.sv
// Bench for modport_bridge: table of single transfers plus hand-written
// back-to-back and mid-transfer reset sequences. Expected APB accesses go
// into a queue when issued and are checked when PENABLE is seen.
module tb_modport_bridge;

    logic        HCLK, HRESET, HWRITE, HREADYin, HREADYout, PENABLE, PWRITE;
    logic [1:0]  HTRANS, HRESP;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR, HWDATA, HRDATA, PRDATA, PADDR, PWDATA;
    logic [3:0]  PSELx;

    int checks   = 0;
    int failures = 0;

`ifdef MODPORT_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int OOW_STALL = ERR_EN ? 1 : 0;

    modport_bridge dut (
        .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HREADYin(HREADYin), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
        .HRDATA(HRDATA), .HRESP(HRESP), .HREADYout(HREADYout),
        .PRDATA(PRDATA), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0]  psel;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  htrans;
        logic        hwrite;
        logic        hready;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  psel;
        int          stall;
        logic        err;
    } vec_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // APB monitor: each ENABLE cycle must match the oldest queued access and
    // be preceded by a SETUP cycle with identical select/address/data.
    logic [3:0]  pv_psel;
    logic        pv_pen, pv_pwr;
    logic [31:0] pv_paddr, pv_pwdata;
    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESET && PENABLE) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL apb_unexpected: got PSELx=%b PADDR=%h expected no access", PSELx, PADDR);
            end else begin
                e = sb.pop_front();
                chk("apb_psel", {28'h0, PSELx}, {28'h0, e.psel});
                chk("apb_pwrite", {31'h0, PWRITE}, {31'h0, e.wr});
                chk("apb_paddr", PADDR, e.addr);
                if (e.wr) chk("apb_pwdata", PWDATA, e.data);
                else      chk("ahb_hrdata", HRDATA, e.data);
                chk("apb_setup_phase",
                    {27'h0, pv_psel == PSELx, !pv_pen, pv_paddr == PADDR,
                     pv_pwr == PWRITE, pv_pwdata == PWDATA}, 32'h1F);
            end
        end
        pv_psel = PSELx; pv_pen = PENABLE; pv_pwr = PWRITE;
        pv_paddr = PADDR; pv_pwdata = PWDATA;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vt[10];
    logic [3:0] bb_psel[5];
    logic       bb_rdy[5];

    initial begin
        vec_t v;
        int   stall;
        logic psel_seen, err_seen;

        vt[0] = '{2'b10, 1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0001, 2, 1'b0};
        vt[1] = '{2'b10, 1'b0, 1'b1, 32'h8400_0004, 32'h1234_5678, 4'b0010, 1, 1'b0};
        vt[2] = '{2'b11, 1'b1, 1'b1, 32'h8FFF_FFFC, 32'h0BAD_F00D, 4'b1000, 2, 1'b0};
        vt[3] = '{2'b10, 1'b0, 1'b1, 32'h8000_0000, 32'h5555_AAAA, 4'b0001, 1, 1'b0};
        vt[4] = '{2'b00, 1'b1, 1'b1, 32'h8000_0040, 32'h1111_2222, 4'b0000, 0, 1'b0};
        vt[5] = '{2'b01, 1'b0, 1'b1, 32'h8400_0040, 32'h3333_4444, 4'b0000, 0, 1'b0};
        vt[6] = '{2'b10, 1'b1, 1'b1, 32'h4000_0000, 32'h6666_7777, 4'b0000, OOW_STALL, ERR_EN};
        vt[7] = '{2'b10, 1'b0, 1'b1, 32'h9000_0000, 32'h8888_9999, 4'b0000, OOW_STALL, ERR_EN};
        vt[8] = '{2'b10, 1'b1, 1'b0, 32'h8800_0008, 32'hAAAA_BBBB, 4'b0000, 0, 1'b0};
        vt[9] = '{2'b11, 1'b0, 1'b1, 32'h7FFF_FFFC, 32'hCCCC_DDDD, 4'b0000, OOW_STALL, ERR_EN};

        HRESET = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HREADYin = 1'b1;
        HADDR = 32'h0; HWDATA = 32'h0; HSIZE = 3'b010; PRDATA = 32'h0;

        // Reset held for two cycles.
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_psel", {28'h0, PSELx}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("rst_hready", {31'h0, HREADYout}, 32'h1);
        chk("rst_hresp", {30'h0, HRESP}, 32'h0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Table of isolated transfers, each started from IDLE.
        for (int i = 0; i < 10; i++) begin
            v = vt[i];
            HTRANS = v.htrans; HWRITE = v.hwrite; HREADYin = v.hready; HADDR = v.addr;
            HWDATA = ~v.data;
            PRDATA = v.hwrite ? 32'h0 : v.data;
            if (v.psel != 4'b0000) sb.push_back('{v.psel, v.hwrite, v.addr, v.data});
            @(posedge HCLK); #1;
            HTRANS = 2'b00; HREADYin = 1'b1; HWDATA = v.data; HADDR = 32'h0;
            stall = 0; psel_seen = 1'b0; err_seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                psel_seen |= (PSELx != 4'b0000);
                err_seen  |= (HRESP != 2'b00);
                if (HREADYout) break;
                stall++;
                @(posedge HCLK); #1;
            end
            chk($sformatf("v%0d_stall", i), stall, v.stall);
            chk($sformatf("v%0d_psel_seen", i), {31'h0, psel_seen}, {31'h0, v.psel != 4'b0000});
            chk($sformatf("v%0d_hresp_err", i), {31'h0, err_seen}, {31'h0, v.err});
            HWDATA = 32'h0;
            @(posedge HCLK); #1;
        end

        // Back-to-back: write issued in the read's ENABLE cycle.
        bb_psel = '{4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000};
        bb_rdy  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8800_0000; PRDATA = 32'hCAFE_0001;
        sb.push_back('{4'b0100, 1'b0, 32'h8800_0000, 32'hCAFE_0001});
        sb.push_back('{4'b1000, 1'b1, 32'h8C00_0000, 32'hA5A5_5A5A});
        @(posedge HCLK); #1;
        HWRITE = 1'b1; HADDR = 32'h8C00_0000;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                HTRANS = 2'b00; HWDATA = 32'hA5A5_5A5A;
            end
            chk($sformatf("b2b_hready_%0d", k), {31'h0, HREADYout}, {31'h0, bb_rdy[k]});
            chk($sformatf("b2b_psel_%0d", k), {28'h0, PSELx}, {28'h0, bb_psel[k]});
            @(posedge HCLK); #1;
        end
        HWDATA = 32'h0;
        @(posedge HCLK); #1;

        // Reset in the middle of a write abandons it.
        HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8000_0020;
        @(posedge HCLK); #1;
        chk("mid_wwait_hready", {31'h0, HREADYout}, 32'h0);
        HRESET = 1'b1; HTRANS = 2'b00; HWDATA = 32'h1111_1111;
        @(posedge HCLK); #1;
        chk("mid_rst_psel", {28'h0, PSELx}, 32'h0);
        chk("mid_rst_hready", {31'h0, HREADYout}, 32'h1);
        chk("mid_rst_paddr", PADDR, 32'h0);
        chk("mid_rst_pwdata", PWDATA, 32'h0);
        chk("mid_rst_pwrite", {31'h0, PWRITE}, 32'h0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        chk("post_rst_psel", {28'h0, PSELx}, 32'h0);
        @(posedge HCLK); #1;
        chk("post_rst_psel2", {28'h0, PSELx}, 32'h0);

        chk("sb_empty", sb.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
